wvb_reader: RTL
===============

# wvb_reader

Waveform buffer readout stage, directly downstream of the waveform buffer storage block. Pops one header per stored waveform from the header FIFO and walks the waveform RAM from the header's start address to its stop address, with wrap. Emits the samples as a valid/ready stream tagged with the header, start-of-packet and end-of-packet, for the readout formatter.

## Interface
Parameters:
- P_DATA_WIDTH, 22, waveform RAM word width; bit 0 is the end-of-event (eoe) flag
- P_ADR_WIDTH, 12, waveform RAM address width
- P_HDR_WIDTH, 80, header width

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset; synchronous, active-high
- en  in  1  readout enable; sampled only in IDLE
- hdr_data  in  P_HDR_WIDTH  header FIFO dout; standard mode, valid one cycle after hdr_rdreq
- hdr_empty  in  1  header FIFO empty
- hdr_rdreq  out  1  header FIFO pop; registered, one-cycle pulse
- wvb_rd_addr  out  P_ADR_WIDTH  waveform RAM read address; registered
- wvb_data  in  P_DATA_WIDTH  RAM doutb; valid one cycle after wvb_rd_addr
- out_data  out  P_DATA_WIDTH  sample
- out_hdr  out  P_HDR_WIDTH  captured header; stable from SOP through EOP
- out_valid, out_sop, out_eop  out  1 each  stream qualifiers
- out_ready  in  1  downstream accept
- busy  out  1  high in any state other than IDLE
- eoe_err  out  1  sticky eoe-mismatch flag (see Configuration)

## Operation
- Header fields: hdr_data[P_ADR_WIDTH-1:0] = stop_addr; hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH] = start_addr. Remaining bits are passed through in out_hdr.
- Sample count: n = ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1, computed P_ADR_WIDTH+1 bits wide. start==stop gives n=1. Maximum n = 2^P_ADR_WIDTH.
- Address increment is modulo 2^P_ADR_WIDTH: it wraps from all-ones to 0.
- FSM states:
  - IDLE: when en & !hdr_empty, go to POP.
  - POP: hdr_rdreq=1 for this cycle only; go to LATCH.
  - LATCH: capture hdr_data into out_hdr; load addr=start_addr and remaining=n; go to STREAM.
  - STREAM: issue one read per cycle while remaining>0 and credit is available; go to DRAIN when remaining reaches 0.
  - DRAIN: wait until the output FIFO is empty and no read is in flight, then go to IDLE.
- Credit rule: issue a read only when fifo_count + in_flight < 4. Returned RAM data is written into a 4-entry output FIFO one cycle after issue. The FIFO must never overflow.
- Stream rules:
  - A beat transfers on out_valid & out_ready.
  - out_sop is set on the first beat of a waveform, out_eop on the n-th.
  - n=1 asserts both on the same beat.
  - out_data and the qualifiers hold while out_valid & !out_ready.
- en falling mid-waveform has no effect; the current waveform completes. en is rechecked in IDLE.
- hdr_empty is ignored outside IDLE, so at most one header is popped per waveform.
- rst at any cycle: state goes to IDLE, the output FIFO is flushed, and any in-flight read is discarded.

## Timing
- Reset values: hdr_rdreq=0, wvb_rd_addr=0, out_valid=0, out_sop=0, out_eop=0, out_hdr=0, out_data=0, busy=0, eoe_err=0.
- Cycle C: IDLE with en & !hdr_empty. Then:
  - hdr_rdreq high in C+1.
  - Header captured at the end of C+2.
  - First wvb_rd_addr presented in C+3.
  - First out_valid in C+5.
- Throughput: one sample per cycle with out_ready held high.
- Back-to-back waveforms: IDLE is re-entered one cycle after the last beat transfers. The inter-waveform gap is at least 6 cycles.

## Configuration
- WVB_RD_EOE_CHECK_EN defined: the eoe bit is checked on every beat.
  - eoe_err is set and stays set until rst if eoe=1 on a non-last beat or eoe=0 on the last beat.
  - The stream itself is unaffected.
- Undefined: no check logic is built and eoe_err is tied 0.

## Structure
- Shared package wvb_pkg holds:
  - header field offsets (stop at 0, start at P_ADR_WIDTH)
  - FSM state enum
  - output FIFO depth constant (4)
- One sub-module, wvb_rd_fifo: 4-entry synchronous FIFO carrying {sop, eop, data}, exposing a count output for the credit rule.

## Test plan
- Single waveform, start=0x010, stop=0x013, out_ready=1 -> 4 beats with data from addresses 0x010..0x013. SOP on beat 1, EOP on beat 4. hdr_rdreq pulses exactly once.
- Wrap, P_ADR_WIDTH=12, start=0xFFE, stop=0x001 -> 4 beats from 0xFFE, 0xFFF, 0x000, 0x001.
- start=stop=0x200 -> one beat with both SOP and EOP. Full span start=0x000, stop=0xFFF -> 4096 beats.
- Random out_ready at 30% duty on a 64-sample waveform -> all 64 samples in order, none duplicated or lost, held stable while stalled, output FIFO never above 4.
- Three headers queued back-to-back -> three packets in order, out_hdr changing only at SOP, exactly three hdr_rdreq pulses.
- rst asserted mid-STREAM -> all outputs at reset values the next cycle. With WVB_RD_EOE_CHECK_EN defined, a missing eoe on the last sample sets eoe_err, which stays set until rst.

Source files
------------

// File: rtl/wvb_pkg.sv
// rtl/wvb_pkg.sv - shared header field offsets, reader FSM states and output FIFO depth
package wvb_pkg;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int HDR_STOP_LSB  = 0;

    // Start address sits directly above the stop address in the header word.
    function automatic int hdr_start_lsb(input int adr_width);
        return adr_width;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LATCH  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } wvb_rd_state_e;

endpackage

// File: rtl/wvb_rd_fifo.sv
// rtl/wvb_rd_fifo.sv - small show-ahead FIFO carrying {sop, eop, data} with occupancy count
module wvb_rd_fifo
    import wvb_pkg::*;
#(
    parameter int P_WIDTH = 24
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push,
    input  logic [P_WIDTH-1:0]                     push_data,
    input  logic                                   pop,
    output logic [P_WIDTH-1:0]                     pop_data,
    output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]     count,
    output logic                                   empty
);
    localparam int AW = $clog2(RD_FIFO_DEPTH);
    localparam int CW = $clog2(RD_FIFO_DEPTH+1);

    logic [P_WIDTH-1:0] mem_q [RD_FIFO_DEPTH];
    logic [P_WIDTH-1:0] mem_d [RD_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push_ok, pop_ok;

    assign push_ok  = push && (count_q != CW'(RD_FIFO_DEPTH));
    assign pop_ok   = pop && (count_q != '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wvb_reader.sv
// rtl/wvb_reader.sv - waveform buffer readout FSM; optional eoe check under WVB_RD_EOE_CHECK_EN
module wvb_reader
    import wvb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_DATA_WIDTH-1:0] out_data,
    output logic [P_HDR_WIDTH-1:0]  out_hdr,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    eoe_err
);
    localparam int AW = P_ADR_WIDTH;
    localparam int FW = P_DATA_WIDTH + 2;
    localparam int CW = $clog2(RD_FIFO_DEPTH+1);

    wvb_rd_state_e    state_q, state_d;
    logic             hdr_rdreq_q, hdr_rdreq_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW:0]      remaining_q, remaining_d;
    logic             first_q, first_d;
    logic [P_HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic             in_flight_q, in_flight_d;
    logic             fl_sop_q, fl_sop_d, fl_eop_q, fl_eop_d;

    logic [AW-1:0]    start_addr, stop_addr, span;
    logic [AW:0]      n_words;
    logic [CW:0]      credit_used;
    logic             issue;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty, fifo_pop;
    logic [FW-1:0]    fifo_dout;

    assign stop_addr  = hdr_data[HDR_STOP_LSB +: AW];
    assign start_addr = hdr_data[hdr_start_lsb(AW) +: AW];
    assign span       = stop_addr - start_addr;
    assign n_words    = {1'b0, span} + (AW+1)'(1);

    // Reads in flight count against FIFO space so a returning word always has a slot.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(in_flight_q);
    assign issue = (state_q == ST_STREAM) && (remaining_q != '0)
                && (credit_used < (CW+1)'(RD_FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        hdr_rdreq_d = 1'b0;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        hdr_d       = hdr_q;
        in_flight_d = issue;
        fl_sop_d    = issue && first_q;
        fl_eop_d    = issue && (remaining_q == (AW+1)'(1));
        case (state_q)
            ST_IDLE: begin
                if (en && !hdr_empty) begin
                    state_d     = ST_POP;
                    hdr_rdreq_d = 1'b1;
                end
            end
            ST_POP: state_d = ST_LATCH;
            ST_LATCH: begin
                hdr_d       = hdr_data;
                addr_d      = start_addr;
                remaining_d = n_words;
                first_d     = 1'b1;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (issue) begin
                    addr_d      = addr_q + AW'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                    first_d     = 1'b0;
                    if (remaining_q == (AW+1)'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the last beat transfers so IDLE follows it by one cycle.
                if (!in_flight_q && ((fifo_count == '0) ||
                    ((fifo_count == CW'(1)) && fifo_pop))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_rdreq_q <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            hdr_q       <= '0;
            in_flight_q <= 1'b0;
            fl_sop_q    <= 1'b0;
            fl_eop_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_rdreq_q <= hdr_rdreq_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            hdr_q       <= hdr_d;
            in_flight_q <= in_flight_d;
            fl_sop_q    <= fl_sop_d;
            fl_eop_q    <= fl_eop_d;
        end
    end

    wvb_rd_fifo #(.P_WIDTH(FW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data ({fl_sop_q, fl_eop_q, wvb_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign fifo_pop    = out_valid && out_ready;
    assign out_data    = fifo_dout[P_DATA_WIDTH-1:0];
    assign out_sop     = out_valid && fifo_dout[FW-1];
    assign out_eop     = out_valid && fifo_dout[FW-2];
    assign out_hdr     = hdr_q;
    assign hdr_rdreq   = hdr_rdreq_q;
    assign wvb_rd_addr = addr_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef WVB_RD_EOE_CHECK_EN
    logic eoe_err_q, eoe_err_d;

    always_comb begin
        eoe_err_d = eoe_err_q;
        if (fifo_pop && (out_data[0] != out_eop)) eoe_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) eoe_err_q <= 1'b0;
        else     eoe_err_q <= eoe_err_d;
    end

    assign eoe_err = eoe_err_q;
`else
    assign eoe_err = 1'b0;
`endif

endmodule
